// File: rtl/mem_to_fifo.sv
// Replay-side read engine: walks each enabled queue's memory window in round-robin,
// issues paired reads and packs each returned pair into one queue-tagged FIFO word.
module mem_to_fifo #(
  parameter int FIFO_DATA_WIDTH = 288,
  parameter int FIFO_NUM_QUEUES = 4,
  parameter int MEM_ADDR_WIDTH  = 19,
  parameter int MEM_DATA_WIDTH  = 72,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sw_rst,
  input  logic                       cal_done,
  input  logic                       start,
  input  logic                       enable_q0,
  input  logic                       enable_q1,
  input  logic                       enable_q2,
  input  logic                       enable_q3,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_ad_low_q0,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_ad_low_q1,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_ad_low_q2,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_ad_low_q3,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_ad_high_q0,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_ad_high_q1,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_ad_high_q2,
  input  logic [MEM_ADDR_WIDTH-1:0]  mem_ad_high_q3,
  input  logic [15:0]                replay_cnt_q0,
  input  logic [15:0]                replay_cnt_q1,
  input  logic [15:0]                replay_cnt_q2,
  input  logic [15:0]                replay_cnt_q3,
  output logic                       mem_r_n,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_ad_rd,
  input  logic                       mem_rd_full,
  input  logic                       mem_rd_valid,
  input  logic [MEM_DATA_WIDTH-1:0]  mem_qrl,
  input  logic [MEM_DATA_WIDTH-1:0]  mem_qrh,
  input  logic [FIFO_NUM_QUEUES-1:0] fifo_almost_full,
  output logic                       fifo_wr_en,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_data,
  output logic [1:0]                 fifo_qid,
  output logic                       busy,
  output logic [FIFO_NUM_QUEUES-1:0] done
);

  localparam int NQ    = FIFO_NUM_QUEUES;
  localparam int TAG_W = $clog2(MAX_OUTSTANDING);
  localparam int OUT_W = TAG_W + 1;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  typedef logic [MEM_ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RD_0 = 2'd1, RD_1 = 2'd2, DRAIN = 2'd3} state_t;

  state_t state_r, state_nxt_s;
  logic [NQ-1:0] en_r, en_in_s, elig_s;
  addr_t low_r [NQ], high_r [NQ], ptr_r [NQ];
  addr_t low_in_s [NQ], high_in_s [NQ];
  logic [15:0] cnt_r [NQ], pass_r [NQ], cnt_in_s [NQ];
  logic [1:0] last_q_r, cur_q_r, sel_q_s, cand_s;
  logic sel_found_s, all_done_s, can_cmd_s, issue0_s, issue1_s, wr_s;
  addr_t cur_ptr_s, ptr_step_s;
  logic [OUT_W-1:0] outstanding_r;
  logic [1:0] tag_mem_r [MAX_OUTSTANDING];
  logic [TAG_W-1:0] tag_wr_r, tag_rd_r;
  logic [2*MEM_DATA_WIDTH-1:0] half_r;
  logic half_valid_r;

  assign en_in_s   = {enable_q3, enable_q2, enable_q1, enable_q0};
  assign low_in_s  = '{mem_ad_low_q0, mem_ad_low_q1, mem_ad_low_q2, mem_ad_low_q3};
  assign high_in_s = '{mem_ad_high_q0, mem_ad_high_q1, mem_ad_high_q2, mem_ad_high_q3};
  assign cnt_in_s  = '{replay_cnt_q0, replay_cnt_q1, replay_cnt_q2, replay_cnt_q3};

  // Round-robin grant search starting after the last granted queue, plus issue qualifiers
  always_comb begin
    elig_s      = en_r & ~done & ~fifo_almost_full;
    all_done_s  = ((en_r & ~done) == {NQ{1'b0}});
    sel_found_s = 1'b0;
    sel_q_s     = 2'd0;
    cand_s      = 2'd0;
    for (int i = 1; i <= NQ; i++) begin
      cand_s      = last_q_r + 2'(i);
      sel_q_s     = (!sel_found_s && elig_s[cand_s]) ? cand_s : sel_q_s;
      sel_found_s = sel_found_s | elig_s[cand_s];
    end
    can_cmd_s  = !mem_rd_full && cal_done;
    issue0_s   = (state_r == RD_0) && !all_done_s && sel_found_s && can_cmd_s &&
                 (outstanding_r < OUT_MAX);
    issue1_s   = (state_r == RD_1) && can_cmd_s;
    wr_s       = mem_rd_valid && half_valid_r;
    cur_ptr_s  = ptr_r[cur_q_r];
    ptr_step_s = cur_ptr_s + addr_t'(2);
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start ? RD_0 : IDLE;
      RD_0: begin
        if (all_done_s) begin
          state_nxt_s = DRAIN;
        end else if (issue0_s) begin
          state_nxt_s = RD_1;
        end else begin
          state_nxt_s = RD_0;
        end
      end
      RD_1:    state_nxt_s = issue1_s ? RD_0 : RD_1;
      DRAIN:   state_nxt_s = (outstanding_r == {OUT_W{1'b0}}) ? IDLE : DRAIN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else if (sw_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Captured configuration, window pointers, pass counters, done flags and busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_r <= '0; low_r <= '{default: '0}; high_r <= '{default: '0}; cnt_r <= '{default: '0};
      ptr_r <= '{default: '0}; pass_r <= '{default: '0}; done <= '0; busy <= 1'b0;
      last_q_r <= 2'd0;
    end else if (sw_rst) begin
      en_r <= '0; low_r <= '{default: '0}; high_r <= '{default: '0}; cnt_r <= '{default: '0};
      ptr_r <= '{default: '0}; pass_r <= '{default: '0}; done <= '0; busy <= 1'b0;
      last_q_r <= 2'd0;
    end else begin
      if (state_r == IDLE && start) begin
        en_r     <= en_in_s;
        low_r    <= low_in_s;
        high_r   <= high_in_s;
        cnt_r    <= cnt_in_s;
        ptr_r    <= low_in_s;
        pass_r   <= '{default: '0};
        done     <= '0;
        busy     <= 1'b1;
        // Park the grant pointer on the last queue so queue 0 is served first
        last_q_r <= 2'(NQ - 1);
      end else if (state_r == DRAIN && outstanding_r == {OUT_W{1'b0}}) begin
        busy <= 1'b0;
      end
      if (issue0_s) begin
        last_q_r <= sel_q_s;
      end
      if (issue1_s) begin
        if (ptr_step_s == high_r[cur_q_r]) begin
          ptr_r[cur_q_r]  <= low_r[cur_q_r];
          pass_r[cur_q_r] <= pass_r[cur_q_r] + 16'd1;
          if (cnt_r[cur_q_r] != 16'd0 && (pass_r[cur_q_r] + 16'd1) == cnt_r[cur_q_r]) begin
            done[cur_q_r] <= 1'b1;
          end
        end else begin
          ptr_r[cur_q_r] <= ptr_step_s;
        end
      end
    end
  end

  // Registered read command and the queue owning the pair in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r_n <= 1'b1; mem_ad_rd <= '0; cur_q_r <= 2'd0;
    end else if (sw_rst) begin
      mem_r_n <= 1'b1; mem_ad_rd <= '0; cur_q_r <= 2'd0;
    end else begin
      mem_r_n <= 1'b1;
      if (issue0_s) begin
        mem_r_n   <= 1'b0;
        mem_ad_rd <= ptr_r[sel_q_s];
        cur_q_r   <= sel_q_s;
      end else if (issue1_s) begin
        mem_r_n   <= 1'b0;
        mem_ad_rd <= cur_ptr_s + addr_t'(1);
      end
    end
  end

  // Return path: beat pairing, tag FIFO and outstanding-pair accounting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr_en <= 1'b0; fifo_data <= '0; fifo_qid <= 2'd0; half_r <= '0; half_valid_r <= 1'b0;
      tag_mem_r <= '{default: '0}; tag_wr_r <= '0; tag_rd_r <= '0; outstanding_r <= '0;
    end else if (sw_rst) begin
      fifo_wr_en <= 1'b0; fifo_data <= '0; fifo_qid <= 2'd0; half_r <= '0; half_valid_r <= 1'b0;
      tag_mem_r <= '{default: '0}; tag_wr_r <= '0; tag_rd_r <= '0; outstanding_r <= '0;
    end else begin
      fifo_wr_en <= wr_s;
      if (mem_rd_valid) begin
        if (half_valid_r) begin
          fifo_data    <= {mem_qrh, mem_qrl, half_r};
          fifo_qid     <= tag_mem_r[tag_rd_r];
          tag_rd_r     <= tag_rd_r + TAG_W'(1);
          half_valid_r <= 1'b0;
        end else begin
          half_r       <= {mem_qrh, mem_qrl};
          half_valid_r <= 1'b1;
        end
      end
      if (issue0_s) begin
        tag_mem_r[tag_wr_r] <= sel_q_s;
        tag_wr_r            <= tag_wr_r + TAG_W'(1);
      end
      case ({issue0_s, wr_s})
        2'b10:   outstanding_r <= outstanding_r + OUT_W'(1);
        2'b01:   outstanding_r <= outstanding_r - OUT_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_to_fifo.sv
// Scoreboard bench for mem_to_fifo: expected commands and FIFO words are queued per
// scenario and compared as the DUT issues reads and writes words.
module tb_mem_to_fifo;
  localparam int AW = 19;
  localparam int DW = 72;
  localparam int FW = 288;

  logic clk = 1'b0;
  logic rst = 1'b1, sw_rst = 1'b0, cal_done = 1'b0, start = 1'b0, mem_rd_full = 1'b0;
  logic mem_rd_valid = 1'b0;
  logic [DW-1:0] mem_qrl = '0, mem_qrh = '0;
  logic [3:0] fifo_almost_full = 4'b0000;
  logic en_a [4];
  logic [AW-1:0] low_a [4], high_a [4];
  logic [15:0] cnt_a [4];
  logic mem_r_n, fifo_wr_en, busy;
  logic [AW-1:0] mem_ad_rd;
  logic [FW-1:0] fifo_data;
  logic [1:0] fifo_qid;
  logic [3:0] done;

  int checks = 0, fails = 0;
  int cyc = 0, cmd_cnt = 0, wr_cnt = 0, max_out = 0, last_wr_cyc = 0, busy_fall_cyc = 0;
  logic busy_q = 1'b0, hold_ret = 1'b0;
  logic [AW-1:0] exp_cmd_q [$];
  logic [FW+1:0] exp_wr_q [$];
  logic [AW-1:0] pend_addr [$];
  int pend_due [$];

  mem_to_fifo dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .cal_done(cal_done), .start(start),
    .enable_q0(en_a[0]), .enable_q1(en_a[1]), .enable_q2(en_a[2]), .enable_q3(en_a[3]),
    .mem_ad_low_q0(low_a[0]), .mem_ad_low_q1(low_a[1]),
    .mem_ad_low_q2(low_a[2]), .mem_ad_low_q3(low_a[3]),
    .mem_ad_high_q0(high_a[0]), .mem_ad_high_q1(high_a[1]),
    .mem_ad_high_q2(high_a[2]), .mem_ad_high_q3(high_a[3]),
    .replay_cnt_q0(cnt_a[0]), .replay_cnt_q1(cnt_a[1]),
    .replay_cnt_q2(cnt_a[2]), .replay_cnt_q3(cnt_a[3]),
    .mem_r_n(mem_r_n), .mem_ad_rd(mem_ad_rd), .mem_rd_full(mem_rd_full),
    .mem_rd_valid(mem_rd_valid), .mem_qrl(mem_qrl), .mem_qrh(mem_qrh),
    .fifo_almost_full(fifo_almost_full), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .fifo_qid(fifo_qid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory contents: each address returns a distinct {qrh,qrl} beat
  function automatic logic [2*DW-1:0] beat_of(input logic [AW-1:0] a);
    return {8'h3C, 45'd0, a, 8'hC3, 45'd0, ~a};
  endfunction

  // Command/write scoreboard and in-order memory responder (latency 2 cycles)
  always @(negedge clk) begin
    logic [AW-1:0] a;
    logic [FW+1:0] e;
    int outs;
    cyc++;
    if (mem_r_n === 1'b0) begin
      cmd_cnt++;
      pend_addr.push_back(mem_ad_rd);
      pend_due.push_back(cyc + 2);
      checks++;
      if (exp_cmd_q.size() == 0) begin
        fails++;
        $display("FAIL cmd_unexpected: got read at %h, required no command", mem_ad_rd);
      end else begin
        a = exp_cmd_q.pop_front();
        if (mem_ad_rd !== a) begin
          fails++;
          $display("FAIL cmd_addr: got %h, required %h", mem_ad_rd, a);
        end
      end
    end
    if (fifo_wr_en === 1'b1) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      checks++;
      if (exp_wr_q.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got qid %0d data %h, required no write", fifo_qid, fifo_data);
      end else begin
        e = exp_wr_q.pop_front();
        if ({fifo_qid, fifo_data} !== e) begin
          fails++;
          $display("FAIL wr_word: got qid %0d data %h, required qid %0d data %h",
                   fifo_qid, fifo_data, e[FW+1:FW], e[FW-1:0]);
        end
      end
    end
    outs = (cmd_cnt + 1) / 2 - wr_cnt;
    if (outs > max_out) max_out = outs;
    if (busy_q && !busy) busy_fall_cyc = cyc;
    busy_q = busy;
    if (!hold_ret && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      mem_rd_valid = 1'b1;
      {mem_qrh, mem_qrl} = beat_of(a);
    end else begin
      mem_rd_valid = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_q(input int q, input logic en, input logic [AW-1:0] lo,
                       input logic [AW-1:0] hi, input logic [15:0] cnt);
    en_a[q] = en; low_a[q] = lo; high_a[q] = hi; cnt_a[q] = cnt;
  endtask

  task automatic clear_qs();
    for (int q = 0; q < 4; q++) set_q(q, 1'b0, 19'h0, 19'h2, 16'd1);
  endtask

  task automatic expect_pair(input logic [1:0] q, input logic [AW-1:0] a);
    exp_cmd_q.push_back(a);
    exp_cmd_q.push_back(a + 19'd1);
    exp_wr_q.push_back({q, beat_of(a + 19'd1), beat_of(a)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      step(1);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    step(1);
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if (mem_r_n !== 1'b1) begin fails++; $display("FAIL reset_mem_r_n: got %b, required 1", mem_r_n); end
    rst = 1'b0;
    cal_done = 1'b1;
    step(1);
    checks++;
    if ({busy, done, fifo_wr_en, fifo_qid} !== 8'h00) begin
      fails++; $display("FAIL reset_outputs: got busy %b done %b wr %b qid %0d, required all 0",
                        busy, done, fifo_wr_en, fifo_qid);
    end
    checks++;
    if (mem_ad_rd !== 19'h0) begin fails++; $display("FAIL reset_addr: got %h, required 0", mem_ad_rd); end
    checks++;
    if (fifo_data !== '0) begin fails++; $display("FAIL reset_data: got %h, required 0", fifo_data); end
  endtask

  task automatic test_single();
    bit ok;
    int cbase, wbase;
    clear_qs();
    set_q(0, 1'b1, 19'h100, 19'h104, 16'd1);
    expect_pair(2'd0, 19'h100);
    expect_pair(2'd0, 19'h102);
    cal_done = 1'b0;
    cbase = cmd_cnt; wbase = wr_cnt;
    pulse_start();
    step(10);
    checks++;
    if (cmd_cnt != cbase) begin fails++; $display("FAIL single_cal_gate: got %0d commands, required 0", cmd_cnt - cbase); end
    cal_done = 1'b1;
    wait_idle(100, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL single_timeout: busy still %b, required 0", busy); end
    checks++;
    if (done !== 4'b0001) begin fails++; $display("FAIL single_done: got %b, required 0001", done); end
    checks++;
    if (wr_cnt - wbase != 2) begin fails++; $display("FAIL single_writes: got %0d, required 2", wr_cnt - wbase); end
    checks++;
    if (busy_fall_cyc - last_wr_cyc != 1) begin
      fails++; $display("FAIL single_busy_fall: got %0d cycles after last write, required 1", busy_fall_cyc - last_wr_cyc);
    end
    checks++;
    if (exp_cmd_q.size() + exp_wr_q.size() != 0) begin
      fails++; $display("FAIL single_leftover: got %0d pending expectations, required 0", exp_cmd_q.size() + exp_wr_q.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int wbase;
    clear_qs();
    set_q(0, 1'b1, 19'h200, 19'h204, 16'd1);
    set_q(2, 1'b1, 19'h300, 19'h304, 16'd1);
    expect_pair(2'd0, 19'h200);
    expect_pair(2'd2, 19'h300);
    expect_pair(2'd0, 19'h202);
    expect_pair(2'd2, 19'h302);
    wbase = wr_cnt;
    pulse_start();
    wait_idle(100, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL rr_timeout: busy still %b, required 0", busy); end
    checks++;
    if (done !== 4'b0101) begin fails++; $display("FAIL rr_done: got %b, required 0101", done); end
    checks++;
    if (wr_cnt - wbase != 4 || exp_cmd_q.size() != 0) begin
      fails++; $display("FAIL rr_count: got %0d writes %0d missing cmds, required 4 and 0", wr_cnt - wbase, exp_cmd_q.size());
    end
  endtask

  task automatic test_wrap_repeat();
    bit ok;
    int wbase;
    clear_qs();
    set_q(1, 1'b1, 19'h10, 19'h12, 16'd3);
    for (int i = 0; i < 3; i++) expect_pair(2'd1, 19'h10);
    wbase = wr_cnt;
    pulse_start();
    wait_idle(100, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL wrap_timeout: busy still %b, required 0", busy); end
    checks++;
    if (done !== 4'b0010) begin fails++; $display("FAIL wrap_done: got %b, required 0010", done); end
    checks++;
    if (wr_cnt - wbase != 3) begin fails++; $display("FAIL wrap_writes: got %0d, required 3", wr_cnt - wbase); end
  endtask

  task automatic test_backpressure_full();
    bit ok;
    int cbase;
    clear_qs();
    set_q(0, 1'b1, 19'h100, 19'h104, 16'd1);
    expect_pair(2'd0, 19'h100);
    expect_pair(2'd0, 19'h102);
    cbase = cmd_cnt;
    ok = 1'b0;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      if (cmd_cnt != cbase) begin ok = 1'b1; break; end
      step(1);
    end
    checks++;
    if (!ok) begin fails++; $display("FAIL full_first_cmd: got %0d commands, required 1", cmd_cnt - cbase); end
    mem_rd_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      checks++;
      if ({mem_r_n, mem_ad_rd} !== {1'b1, 19'h100}) begin
        fails++; $display("FAIL full_hold: got r_n %b addr %h, required 1 and 00100", mem_r_n, mem_ad_rd);
      end
    end
    mem_rd_full = 1'b0;
    wait_idle(100, ok);
    checks++;
    if (!ok || exp_cmd_q.size() + exp_wr_q.size() != 0) begin
      fails++; $display("FAIL full_finish: got idle %b with %0d pending, required 1 and 0", ok, exp_cmd_q.size() + exp_wr_q.size());
    end
  endtask

  task automatic test_backpressure_af();
    bit ok;
    int cbase;
    clear_qs();
    set_q(0, 1'b1, 19'h100, 19'h104, 16'd1);
    set_q(1, 1'b1, 19'h180, 19'h184, 16'd1);
    expect_pair(2'd1, 19'h180);
    expect_pair(2'd1, 19'h182);
    expect_pair(2'd0, 19'h100);
    expect_pair(2'd0, 19'h102);
    fifo_almost_full = 4'b0001;
    cbase = cmd_cnt;
    pulse_start();
    step(40);
    checks++;
    if (cmd_cnt - cbase != 4) begin fails++; $display("FAIL af_block: got %0d commands, required 4", cmd_cnt - cbase); end
    checks++;
    if (done !== 4'b0010) begin fails++; $display("FAIL af_done_mid: got %b, required 0010", done); end
    fifo_almost_full = 4'b0000;
    wait_idle(100, ok);
    checks++;
    if (!ok || done !== 4'b0011) begin fails++; $display("FAIL af_finish: got idle %b done %b, required 1 and 0011", ok, done); end
  endtask

  task automatic test_no_queue();
    bit ok;
    int cbase;
    clear_qs();
    cbase = cmd_cnt;
    pulse_start();
    wait_idle(10, ok);
    checks++;
    if (!ok || cmd_cnt != cbase || done !== 4'b0000) begin
      fails++; $display("FAIL none: got idle %b cmds %0d done %b, required 1, 0, 0000", ok, cmd_cnt - cbase, done);
    end
  endtask

  task automatic test_outstanding();
    bit ok;
    int cbase;
    clear_qs();
    set_q(0, 1'b1, 19'h000, 19'h040, 16'd1);
    for (int i = 0; i < 32; i++) expect_pair(2'd0, 19'(2 * i));
    hold_ret = 1'b1;
    cbase = cmd_cnt;
    pulse_start();
    step(60);
    checks++;
    if (cmd_cnt - cbase != 16) begin fails++; $display("FAIL cap_stall: got %0d commands, required 16", cmd_cnt - cbase); end
    hold_ret = 1'b0;
    wait_idle(500, ok);
    checks++;
    if (!ok || exp_wr_q.size() != 0) begin fails++; $display("FAIL cap_resume: got idle %b with %0d writes missing, required 1 and 0", ok, exp_wr_q.size()); end
    checks++;
    if (max_out != 8) begin fails++; $display("FAIL cap_max: got peak %0d outstanding pairs, required 8", max_out); end
  endtask

  task automatic test_infinite_reset();
    bit ok;
    int cbase;
    clear_qs();
    set_q(3, 1'b1, 19'h40, 19'h44, 16'd0);
    for (int i = 0; i < 5; i++) begin
      expect_pair(2'd3, 19'h40);
      expect_pair(2'd3, 19'h42);
    end
    cbase = cmd_cnt;
    ok = 1'b0;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (cmd_cnt - cbase >= 17) begin ok = 1'b1; break; end
      step(1);
    end
    checks++;
    if (!ok) begin fails++; $display("FAIL inf_progress: got %0d commands, required 17", cmd_cnt - cbase); end
    checks++;
    if (busy !== 1'b1 || done !== 4'b0000) begin fails++; $display("FAIL inf_running: got busy %b done %b, required 1 and 0000", busy, done); end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_r_n, busy, done} !== 6'b100000) begin
      fails++; $display("FAIL inf_reset: got r_n %b busy %b done %b, required 1, 0, 0000", mem_r_n, busy, done);
    end
    hold_ret = 1'b1;
    step(2);
    exp_cmd_q.delete(); exp_wr_q.delete(); pend_addr.delete(); pend_due.delete();
    rst = 1'b0;
    hold_ret = 1'b0;
    step(3);
    checks++;
    if ({mem_r_n, busy} !== 2'b10) begin fails++; $display("FAIL inf_after: got r_n %b busy %b, required 1 and 0", mem_r_n, busy); end
  endtask

  initial begin
    clear_qs();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_repeat();
    test_backpressure_full();
    test_backpressure_af();
    test_no_queue();
    test_outstanding();
    test_infinite_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
